// File: rtl/reqack_pkg.sv
// Shared types and helpers for the req/ack responder: FSM state encoding,
// default latency bound and the latency clamp.
package reqack_pkg;

  localparam int unsigned DEF_MAX_LAT = 5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACK,
    DONE,
    WLOW
  } state_e;

  // Effective ack latency: requested value bounded by the configured maximum.
  function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned max_lat);
    return (lat > max_lat) ? max_lat : lat;
  endfunction

endpackage

// File: rtl/reqack_lat_counter.sv
// Latency down-counter with zero detect, plus the saturating interrupt counter.
module reqack_lat_counter #(
  parameter int LAT_W  = 3,
  parameter int ICNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [LAT_W-1:0]  load_val,
  input  logic              dec,
  input  logic              icnt_inc,
  output logic              cnt_zero,
  output logic [ICNT_W-1:0] intr_cnt
);

  logic [LAT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 cnt_q <= '0;
    else if (load)                cnt_q <= load_val;
    else if (dec && cnt_q != '0)  cnt_q <= cnt_q - LAT_W'(1);
  end

  assign cnt_zero = (cnt_q == '0);

  // Sticks at all-ones once reached.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        intr_cnt <= '0;
    else if (icnt_inc && intr_cnt != '1) intr_cnt <= intr_cnt + ICNT_W'(1);
  end

endmodule

// File: rtl/reqack_responder.sv
// Request/acknowledge responder: programmable-latency ack, trailing done pulse,
// intrpt on early request withdrawal, and a one-cycle delayed copy of req.
module reqack_responder
  import reqack_pkg::*;
#(
  parameter int unsigned MAX_LAT = DEF_MAX_LAT,
  parameter int          LAT_W   = 3,
  parameter int          ICNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic [LAT_W-1:0]  lat_cfg,
  input  logic              abort,
  output logic              ack,
  output logic              done,
  output logic              intrpt,
  output logic              req_delay_cp1,
  output logic              busy,
  output logic [ICNT_W-1:0] intr_cnt
);

  state_e           state_q, state_d;
  logic             ack_d, done_d, intrpt_d;
  logic             cnt_load, cnt_dec, cnt_zero, icnt_inc;
  logic [LAT_W-1:0] lat_eff;

  assign lat_eff = LAT_W'(clamp_lat(32'(lat_cfg), MAX_LAT));

  reqack_lat_counter #(
    .LAT_W  (LAT_W),
    .ICNT_W (ICNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (lat_eff),
    .dec      (cnt_dec),
    .icnt_inc (icnt_inc),
    .cnt_zero (cnt_zero),
    .intr_cnt (intr_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // A req drop in WAIT outranks the zero-count ack; abort outranks everything.
  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    intrpt_d = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    icnt_inc = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          state_d  = WAIT;
          cnt_load = 1'b1;
        end
        WAIT: begin
          if (!req) begin
            state_d  = IDLE;
            intrpt_d = 1'b1;
            icnt_inc = 1'b1;
          end else if (cnt_zero) begin
            state_d = ACK;
            ack_d   = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ACK: begin
          state_d = DONE;
          done_d  = 1'b1;
        end
        DONE:    state_d = req ? WLOW : IDLE;
        WLOW:    if (!req) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack           <= 1'b0;
      done          <= 1'b0;
      intrpt        <= 1'b0;
      busy          <= 1'b0;
      req_delay_cp1 <= 1'b0;
    end else begin
      ack           <= ack_d;
      done          <= done_d;
      intrpt        <= intrpt_d;
      busy          <= (state_d != IDLE);
      req_delay_cp1 <= req;
    end
  end

endmodule

// File: tb/tb_reqack_responder.sv
// Directed bench for reqack_responder: table of per-cycle req patterns with
// hand-computed output masks, plus abort, saturation and async-reset sequences.
module tb_reqack_responder;
  localparam int LAT_W  = 3;
  localparam int ICNT_W = 8;
  localparam int WIN    = 16;
  localparam int NV     = 8;

  typedef struct {
    logic [LAT_W-1:0] lat;
    logic [WIN-1:0]   req;   // bit k: req as seen at edge N+k
    logic [WIN-1:0]   ack;   // bit k: expected value in the cycle after edge N+k
    logic [WIN-1:0]   done;
    logic [WIN-1:0]   intr;
    logic [WIN-1:0]   busy;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req = 1'b0;
  logic              abort = 1'b0;
  logic [LAT_W-1:0]  lat_cfg = '0;
  logic              ack, done, intrpt, req_delay_cp1, busy;
  logic [ICNT_W-1:0] intr_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int icnt_m = 0;
  vec_t tbl [NV];

  reqack_responder #(.MAX_LAT(5), .LAT_W(LAT_W), .ICNT_W(ICNT_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .lat_cfg       (lat_cfg),
    .abort         (abort),
    .ack           (ack),
    .done          (done),
    .intrpt        (intrpt),
    .req_delay_cp1 (req_delay_cp1),
    .busy          (busy),
    .intr_cnt      (intr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [WIN-1:0] bits(input int lo, input int hi);
    logic [WIN-1:0] m = '0;
    for (int j = lo; j <= hi; j++) m[j] = 1'b1;
    return m;
  endfunction

  // Flags are {ack, done, intrpt, busy, req_delay_cp1}.
  task automatic chk_flags(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: {ack,done,intrpt,busy,rd1} got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_val(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    tbl[0] = '{3'd3, bits(0,9),  bits(4,4), bits(5,5), '0,        bits(0,9)};
    tbl[1] = '{3'd0, bits(0,2),  bits(1,1), bits(2,2), '0,        bits(0,2)};
    tbl[2] = '{3'd7, bits(0,11), bits(6,6), bits(7,7), '0,        bits(0,11)};
    tbl[3] = '{3'd4, bits(0,1),  '0,        '0,        bits(2,2), bits(0,1)};
    tbl[4] = '{3'd0, bits(0,0),  '0,        '0,        bits(1,1), bits(0,0)};
    tbl[5] = '{3'd2, bits(0,3),  bits(3,3), bits(4,4), '0,        bits(0,4)};
    tbl[6] = '{3'd5, bits(0,5),  '0,        '0,        bits(6,6), bits(0,5)};
    tbl[7] = '{3'd1, bits(0,5) | bits(7,15), bits(2,2) | bits(9,9),
               bits(3,3) | bits(10,10), '0, bits(0,5) | bits(7,15)};

    // Reset state
    repeat (2) @(negedge clk);
    chk_flags("reset_flags", {ack, done, intrpt, busy, req_delay_cp1}, 5'b0);
    chk_val("reset_intr_cnt", int'(intr_cnt), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      int ni;
      ni = 0;
      lat_cfg = tbl[i].lat;
      req = tbl[i].req[0];
      for (int k = 0; k < WIN; k++) begin
        @(negedge clk);
        chk_flags($sformatf("vec%0d_k%0d", i, k),
                  {ack, done, intrpt, busy, req_delay_cp1},
                  {tbl[i].ack[k], tbl[i].done[k], tbl[i].intr[k], tbl[i].busy[k], tbl[i].req[k]});
        if (tbl[i].intr[k]) ni++;
        req = (k + 1 < WIN) ? tbl[i].req[k+1] : 1'b0;
      end
      req = 1'b0;
      repeat (3) @(negedge clk);
      icnt_m += ni;
      chk_val($sformatf("vec%0d_intr_cnt", i), int'(intr_cnt), icnt_m);
    end

    // Abort in WAIT coinciding with a req drop: abort wins, no intrpt.
    lat_cfg = 3'd3;
    req = 1'b1;
    @(negedge clk);
    chk_flags("abort_k0", {ack, done, intrpt, busy, req_delay_cp1}, 5'b00011);
    @(negedge clk);
    abort = 1'b1;
    req = 1'b0;
    @(negedge clk);
    chk_flags("abort_idle", {ack, done, intrpt, busy, req_delay_cp1}, 5'b00000);
    chk_val("abort_intr_cnt", int'(intr_cnt), icnt_m);
    abort = 1'b0;
    repeat (6) @(negedge clk);
    chk_flags("abort_after", {ack, done, intrpt, busy, req_delay_cp1}, 5'b00000);

    // Saturation of the interrupt counter
    lat_cfg = 3'd4;
    for (int r = 0; r < 300; r++) begin
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      if (r == 0) chk_flags("sat_first_intr", {ack, done, intrpt, busy, req_delay_cp1}, 5'b00100);
      @(negedge clk);
      icnt_m = (icnt_m < 255) ? icnt_m + 1 : 255;
    end
    chk_val("sat_intr_cnt", int'(intr_cnt), 255);
    chk_val("sat_model", int'(intr_cnt), icnt_m);

    // Asynchronous reset in WAIT, then re-acceptance of a held req.
    lat_cfg = 3'd5;
    req = 1'b1;
    repeat (2) @(negedge clk);
    chk_flags("prerst_wait", {ack, done, intrpt, busy, req_delay_cp1}, 5'b00011);
    #2 reset_n = 1'b0;
    #1;
    chk_flags("rst_async_flags", {ack, done, intrpt, busy, req_delay_cp1}, 5'b00000);
    chk_val("rst_async_intr_cnt", int'(intr_cnt), 0);
    icnt_m = 0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_flags($sformatf("rst_reaccept_k%0d", k), {ack, done, intrpt, busy, req_delay_cp1},
                {k == 6, k == 7, 1'b0, 1'b1, 1'b1});
    end
    req = 1'b0;
    repeat (2) @(negedge clk);
    chk_flags("final_idle", {ack, done, intrpt, busy, req_delay_cp1}, 5'b00000);
    chk_val("final_intr_cnt", int'(intr_cnt), icnt_m);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reqack_responder.md
Name: reqack_responder

Overview:
- Request/acknowledge responder that drives `ack`, `done` and `intrpt` for the req/ack equivalence checker, which sits directly downstream and consumes these signals.
- Samples `req` from the requester and returns a single-cycle `ack` after a programmable latency, followed by a single-cycle `done`.
- Flags a request withdrawn before acknowledge with an `intrpt` pulse.
- Also produces `req_delay_cp1`, a one-cycle-delayed copy of `req` used by the checker.

Parameters:
- MAX_LAT, 5, maximum ack latency in cycles; `lat_cfg` values above it are clamped to it.
- LAT_W, 3, width of `lat_cfg` and of the internal latency counter; must satisfy 2**LAT_W > MAX_LAT.
- ICNT_W, 8, width of the saturating interrupt counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  1  request from requester; must hold high until ack.
- lat_cfg  input  LAT_W  requested ack latency L; sampled only when a request is accepted.
- abort  input  1  synchronous abort; returns the FSM to IDLE.
- ack  output  1  one-cycle acknowledge pulse.
- done  output  1  one-cycle completion pulse, the cycle after ack.
- intrpt  output  1  one-cycle pulse when req drops before ack.
- req_delay_cp1  output  1  req registered once.
- busy  output  1  high while a transaction is in progress (any state other than IDLE).
- intr_cnt  output  ICNT_W  saturating count of intrpt pulses.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; ack, done, intrpt, req_delay_cp1, busy all 0; intr_cnt=0; internal counter=0.
- All outputs are registered. `req_delay_cp1` is loaded with `req` every edge.
- Effective latency: Le = min(lat_cfg, MAX_LAT).
- FSM states: IDLE, WAIT, ACK, DONE, WLOW. Evaluated at each posedge.
- `abort` has the highest priority. From any state it forces IDLE and clears ack, done and busy. It never raises intrpt.
- IDLE: if req=1, go to WAIT, cnt<=Le, busy<=1.
- WAIT:
  - If req=0: go to IDLE, intrpt<=1, busy<=0, intr_cnt++ (saturates at all-ones, holds there).
  - Else if cnt=0: go to ACK, ack<=1.
  - Else: cnt<=cnt-1.
- Ack timing: with req first sampled high at edge N, ack is high during the cycle following edge N+1+Le.
  - Le=0 gives ack one cycle after acceptance.
  - If req drops at the same edge where cnt=0, the drop wins: intrpt, no ack.
- ACK: ack<=0, done<=1, go to DONE. A req drop during ACK is legal and raises no intrpt.
- DONE: done<=0.
  - If req=0, go to IDLE with busy<=0.
  - Else go to WLOW.
- WLOW: hold until req=0, then go to IDLE with busy<=0. No new request is accepted until req has been seen low.
- Invariants:
  - ack, done and intrpt are each at most one cycle wide and are mutually exclusive.
  - Exactly one done follows every ack.
  - No ack is issued without a preceding acceptance in IDLE.
- Reset mid-transaction: all outputs drop immediately (asynchronous). After reset release a fresh request is required; a req still held high is re-accepted in IDLE.

Decomposition:
- Package reqack_pkg holds:
  - the state enum typedef (IDLE, WAIT, ACK, DONE, WLOW);
  - the default MAX_LAT constant;
  - a clamp function for Le.
- One natural sub-module: reqack_lat_counter. It handles load, decrement and zero-detect for the latency counter, plus the saturating intr_cnt logic.
- The FSM stays in reqack_responder.

Test Plan:
- lat_cfg=3, req high from edge 10 and held → ack high in cycle after edge 14; done in cycle after edge 15; busy 1 from edge 10 until req is seen low.
- lat_cfg=0 → ack in cycle after edge N+1; done one cycle later.
- lat_cfg=7 with MAX_LAT=5 → ack in cycle after edge N+6 (clamped to 5).
- req dropped at edge N+2 with lat_cfg=4 → intrpt pulse one cycle, no ack/done, intr_cnt=1, back to IDLE. Repeating 300 times → intr_cnt saturates at 255.
- req held high through done → FSM sits in WLOW, no second ack. req low then high again → new ack after Le+1 cycles.
- reset_n pulsed low while in WAIT → ack/done/busy/intrpt 0 immediately. abort=1 during WAIT → IDLE, no intrpt, intr_cnt unchanged.
